// File: rtl/clkdiv_seq_pkg.sv
// Shared types and constants for the clock-divider sequencer.
// The state encoding and LOAD hold time are used by the top-level controller.
package clkdiv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        NEXT
    } state_t;

    localparam int LOAD_CYCLES   = 2;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_DWELL_W   = 16;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]   scale;
        logic [DEF_DWELL_W-1:0] dwell;
    } entry_t;

endpackage

// File: rtl/clkdiv_seq_table.sv
// Register file of (scale, dwell) entries: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module clkdiv_seq_table
    import clkdiv_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk_in,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [WIDTH-1:0]   wscale_i,
    input  logic [DWELL_W-1:0] wdwell_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [WIDTH-1:0]   rscale_o,
    output logic [DWELL_W-1:0] rdwell_o
);

    logic [WIDTH-1:0]   scaleMem_q [DEPTH];
    logic [DWELL_W-1:0] dwellMem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we_i) begin
            scaleMem_q[waddr_i] <= wscale_i;
            dwellMem_q[waddr_i] <= wdwell_i;
        end
    end

    assign rscale_o = scaleMem_q[raddr_i];
    assign rdwell_o = dwellMem_q[raddr_i];

endmodule

// File: rtl/clkdiv_sequencer.sv
// Steps an external clock divider through a table of (scale, dwell) entries,
// holding it in reset while a new scale is applied, then counting its edges.
module clkdiv_sequencer
    import clkdiv_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk_in,
    input  logic               nrst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [WIDTH-1:0]   cfg_scale,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW-1:0]      num_last,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    input  logic               div_clk,
    output logic [WIDTH-1:0]   div_scale,
    output logic               div_nrst,
    output logic               busy,
    output logic [AW-1:0]      cur_idx,
    output logic               done
);

    localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    state_t             state_q;
    logic [WIDTH-1:0]   divScale_q;
    logic               divNrst_q;
    logic               busy_q;
    logic               done_q;
    logic [AW-1:0]      curIdx_q;
    logic [AW-1:0]      curIdx_d;
    logic [AW-1:0]      numLast_q;
    logic               divClk_q;
    logic [DWELL_W-1:0] dwellCnt_q;
    logic [LCW-1:0]     loadCnt_q;

    logic [WIDTH-1:0]   rdScale;
    logic [DWELL_W-1:0] rdDwell;
    logic [DWELL_W-1:0] effDwell;
    logic               rise;
    logic               inc;
    logic               lastCount;
    logic               finalEntry;

    // The table is read at the next index so the new scale lands on the same
    // edge that enters LOAD.
    always_comb begin
        curIdx_d = curIdx_q;
        case (state_q)
            IDLE: if (start && !stop) curIdx_d = '0;
            NEXT: if (!stop) begin
                if (curIdx_q != numLast_q) curIdx_d = curIdx_q + AW'(1);
                else if (!done_q)          curIdx_d = '0;
            end
            default: curIdx_d = curIdx_q;
        endcase
    end

    clkdiv_seq_table #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W),
        .AW      (AW)
    ) u_table (
        .clk_in   (clk_in),
        .we_i     (cfg_we && (state_q == IDLE)),
        .waddr_i  (cfg_addr),
        .wscale_i (cfg_scale),
        .wdwell_i (cfg_dwell),
        .raddr_i  (curIdx_d),
        .rscale_o (rdScale),
        .rdwell_o (rdDwell)
    );

    assign rise       = div_clk & ~divClk_q;
    assign inc        = (divScale_q != '0) ? rise : 1'b1;
    assign effDwell   = (rdDwell == '0) ? DWELL_W'(1) : rdDwell;
    assign lastCount  = (dwellCnt_q >= effDwell - DWELL_W'(1));
    assign finalEntry = (curIdx_q == numLast_q) && !loop_en;

    // done is raised on entry to NEXT and also tells NEXT whether to stop.
    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            state_q    <= IDLE;
            divScale_q <= '0;
            divNrst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            curIdx_q   <= '0;
            numLast_q  <= '0;
            divClk_q   <= 1'b0;
            dwellCnt_q <= '0;
            loadCnt_q  <= '0;
        end else begin
            divClk_q <= div_clk;
            done_q   <= 1'b0;
            curIdx_q <= curIdx_d;
            case (state_q)
                IDLE: begin
                    divNrst_q <= 1'b0;
                    if (start && !stop) begin
                        numLast_q  <= num_last;
                        divScale_q <= rdScale;
                        loadCnt_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    dwellCnt_q <= '0;
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (loadCnt_q == LCW'(LOAD_CYCLES - 1)) begin
                        divNrst_q <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        loadCnt_q <= loadCnt_q + LCW'(1);
                    end
                end
                RUN: begin
                    if (stop) begin
                        divNrst_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (inc) begin
                        if (lastCount) begin
                            divNrst_q <= 1'b0;
                            done_q    <= finalEntry;
                            state_q   <= NEXT;
                        end else if (dwellCnt_q != '1) begin
                            dwellCnt_q <= dwellCnt_q + DWELL_W'(1);
                        end
                    end
                end
                NEXT: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if ((curIdx_q != numLast_q) || !done_q) begin
                        divScale_q <= rdScale;
                        loadCnt_q  <= '0;
                        state_q    <= LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_scale = divScale_q;
    assign div_nrst  = divNrst_q;
    assign busy      = busy_q;
    assign cur_idx   = curIdx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_clkdiv_sequencer.sv
// Scoreboard bench for clkdiv_sequencer: stimulus queues the expected RUN
// windows and done pulses, a monitor measures each window and compares.
module tb_clkdiv_sequencer;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int DWELL_W = 16;
    localparam int AW      = 2;

    logic               clk_in    = 1'b0;
    logic               nrst      = 1'b0;
    logic               cfg_we    = 1'b0;
    logic [AW-1:0]      cfg_addr  = '0;
    logic [WIDTH-1:0]   cfg_scale = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [AW-1:0]      num_last  = '0;
    logic               loop_en   = 1'b0;
    logic               start     = 1'b0;
    logic               stop      = 1'b0;
    logic               div_clk   = 1'b0;
    logic [WIDTH-1:0]   div_scale;
    logic               div_nrst;
    logic               busy;
    logic [AW-1:0]      cur_idx;
    logic               done;

    always #5 clk_in = ~clk_in;

    clkdiv_sequencer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W),
        .AW      (AW)
    ) dut (
        .clk_in    (clk_in),
        .nrst      (nrst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_scale (cfg_scale),
        .cfg_dwell (cfg_dwell),
        .num_last  (num_last),
        .loop_en   (loop_en),
        .start     (start),
        .stop      (stop),
        .div_clk   (div_clk),
        .div_scale (div_scale),
        .div_nrst  (div_nrst),
        .busy      (busy),
        .cur_idx   (cur_idx),
        .done      (done)
    );

    typedef struct {
        bit isDone;
        int idx;
        int scale;
        int count;
    } exp_t;

    exp_t expQ[$];
    int   nChecks     = 0;
    int   nErrors     = 0;
    int   windowsSeen = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Stand-in divider: held low in reset, toggles every 2 clk_in cycles when released.
    int divCnt = 0;
    always @(posedge clk_in) begin
        #2;
        if (!div_nrst) begin
            divCnt  = 0;
            div_clk = 1'b0;
        end else begin
            divCnt++;
            if (divCnt == 2) begin
                divCnt  = 0;
                div_clk = ~div_clk;
            end
        end
    end

    // Monitor: a window is the span with div_nrst high; it ends normally when busy stays high.
    logic prevNrst = 1'b0;
    logic prevClk  = 1'b0;
    int   winCnt   = 0;
    int   winIdx   = 0;
    int   winScale = 0;
    always @(negedge clk_in) begin
        exp_t e;
        if (div_nrst === 1'b1 && prevNrst === 1'b0) begin
            winCnt   = 0;
            winIdx   = int'(cur_idx);
            winScale = int'(div_scale);
        end
        if (div_nrst === 1'b1 && (div_scale == '0 || (div_clk && !prevClk)))
            winCnt++;
        if (div_nrst === 1'b0 && prevNrst === 1'b1 && busy === 1'b1) begin
            windowsSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected window idx", winIdx, -1);
            end else begin
                e = expQ.pop_front();
                checkOutput("window is not done", int'(e.isDone), 0);
                checkOutput("window idx", winIdx, e.idx);
                checkOutput("window scale", winScale, e.scale);
                checkOutput("window edge count", winCnt, e.count);
            end
        end
        if (done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected done", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("done in order", int'(e.isDone), 1);
            end
        end
        prevNrst = div_nrst;
        prevClk  = div_clk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic writeEntry(input int a, input int s, input int d);
        @(negedge clk_in);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_scale = WIDTH'(s);
        cfg_dwell = DWELL_W'(d);
        @(negedge clk_in);
        cfg_we    = 1'b0;
    endtask

    task automatic applyStimulus(input bit st, input bit sp);
        @(negedge clk_in);
        start = st;
        stop  = sp;
        @(negedge clk_in);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pushWin(input int idx, input int scale, input int count);
        exp_t e;
        e.isDone = 1'b0;
        e.idx    = idx;
        e.scale  = scale;
        e.count  = count;
        expQ.push_back(e);
    endtask

    task automatic pushDone();
        exp_t e;
        e.isDone = 1'b1;
        e.idx    = 0;
        e.scale  = 0;
        e.count  = 0;
        expQ.push_back(e);
    endtask

    task automatic waitIdle(input string name, input int maxCyc);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while ((busy !== 1'b0 || expQ.size() != 0) && n < maxCyc);
        checkOutput({name, " queue drained"}, expQ.size(), 0);
        checkOutput({name, " busy"}, int'(busy), 0);
    endtask

    task automatic waitNrstHigh(input string name, input int maxCyc);
        int n = 0;
        while (div_nrst !== 1'b1 && n < maxCyc) begin
            tick(1);
            n++;
        end
        checkOutput({name, " reached RUN"}, int'(div_nrst), 1);
    endtask

    task automatic waitWindows(input string name, input int target, input int maxCyc);
        int n = 0;
        while (windowsSeen < target && n < maxCyc) begin
            tick(1);
            n++;
        end
        checkOutput({name, " windows seen"}, windowsSeen, target);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", nErrors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;

        // Reset and idle outputs
        nrst = 1'b0;
        tick(3);
        checkOutput("reset div_nrst", int'(div_nrst), 0);
        checkOutput("reset div_scale", int'(div_scale), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset cur_idx", int'(cur_idx), 0);
        nrst = 1'b1;
        tick(2);
        checkOutput("idle div_nrst", int'(div_nrst), 0);

        // Single entry, non-looping, with LOAD latency checks
        writeEntry(0, 2, 3);
        num_last = 2'd0;
        loop_en  = 1'b0;
        pushWin(0, 2, 3);
        pushDone();
        applyStimulus(1'b1, 1'b0);
        checkOutput("load1 busy", int'(busy), 1);
        checkOutput("load1 div_nrst", int'(div_nrst), 0);
        checkOutput("load1 div_scale", int'(div_scale), 2);
        tick(1);
        checkOutput("load2 div_nrst", int'(div_nrst), 0);
        tick(1);
        checkOutput("run div_nrst", int'(div_nrst), 1);
        waitIdle("single entry", 200);

        // Three entries including a pass-through (scale 0) entry
        writeEntry(0, 1, 2);
        writeEntry(1, 3, 1);
        writeEntry(2, 0, 5);
        num_last = 2'd2;
        pushWin(0, 1, 2);
        pushWin(1, 3, 1);
        pushWin(2, 0, 5);
        pushDone();
        applyStimulus(1'b1, 1'b0);
        waitIdle("three entries", 300);

        // Looping sequence, aborted by stop while in RUN
        loop_en = 1'b1;
        base = windowsSeen;
        pushWin(0, 1, 2);
        pushWin(1, 3, 1);
        pushWin(2, 0, 5);
        pushWin(0, 1, 2);
        pushWin(1, 3, 1);
        applyStimulus(1'b1, 1'b0);
        waitWindows("loop", base + 5, 400);
        waitNrstHigh("loop third", 20);
        checkOutput("loop stop idx", int'(cur_idx), 2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        checkOutput("stop busy", int'(busy), 0);
        checkOutput("stop div_nrst", int'(div_nrst), 0);
        checkOutput("stop done", int'(done), 0);
        checkOutput("stop queue", expQ.size(), 0);
        loop_en = 1'b0;
        tick(3);

        // Dwell 0 acts as 1; writes while busy are dropped
        writeEntry(0, 1, 2);
        writeEntry(1, 2, 0);
        num_last = 2'd1;
        pushWin(0, 1, 2);
        pushWin(1, 2, 1);
        pushDone();
        applyStimulus(1'b1, 1'b0);
        waitNrstHigh("dwell0 pass1", 20);
        writeEntry(0, 3, 7);
        waitIdle("dwell0 pass1", 300);
        pushWin(0, 1, 2);
        pushWin(1, 2, 1);
        pushDone();
        applyStimulus(1'b1, 1'b0);
        waitIdle("dwell0 pass2", 300);

        // start and stop together stay in IDLE
        applyStimulus(1'b1, 1'b1);
        checkOutput("start+stop busy", int'(busy), 0);
        tick(2);
        checkOutput("start+stop later busy", int'(busy), 0);
        checkOutput("start+stop div_nrst", int'(div_nrst), 0);

        // Reset in the middle of RUN, then a clean restart from entry 0
        applyStimulus(1'b1, 1'b0);
        waitNrstHigh("midreset", 20);
        nrst = 1'b0;
        tick(1);
        nrst = 1'b1;
        checkOutput("midreset div_nrst", int'(div_nrst), 0);
        checkOutput("midreset div_scale", int'(div_scale), 0);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset cur_idx", int'(cur_idx), 0);
        checkOutput("midreset done", int'(done), 0);
        pushWin(0, 1, 2);
        pushWin(1, 2, 1);
        pushDone();
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart cur_idx", int'(cur_idx), 0);
        waitIdle("restart", 300);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/clkdiv_sequencer.md
Name: clkdiv_sequencer

Overview:
Controller that reprograms the existing clock divider through a small table of (scale, dwell) entries without software involvement. For each entry it drives the divider's scale and reset, holds the divider in reset long enough to capture the new scale, then releases it. It counts rising edges of the divided clock and advances to the next entry after the programmed number of edges. Sits beside the divider at top level: drives the divider's scale and nrst inputs and samples its clk_out. It does not instantiate the divider.

Parameters:
WIDTH, 8, scale width; must match the divider's WIDTH.
DEPTH, 4, number of table entries (power of 2, at least 2).
DWELL_W, 16, width of the dwell count per entry.
AW, $clog2(DEPTH), width of the table address.

Ports:
clk_in     in   1        system clock (same clock as the divider)
nrst       in   1        synchronous active-low reset
cfg_we     in   1        table write strobe
cfg_addr   in   AW       table write index
cfg_scale  in   WIDTH    scale value written to the entry
cfg_dwell  in   DWELL_W  divided-clock rising edges to spend in the entry
num_last   in   AW       index of the last active entry (sampled at start)
loop_en    in   1        1: wrap from the last entry to entry 0; 0: stop after the last entry
start      in   1        start sequencing (level-sampled in IDLE)
stop       in   1        abort sequencing
div_clk    in   1        divider clk_out
div_scale  out  WIDTH    to the divider's scale input
div_nrst   out  1        to the divider's nrst input
busy       out  1        high in LOAD, RUN and NEXT
cur_idx    out  AW       entry currently applied
done       out  1        one-cycle pulse when a non-looping sequence completes

Behaviour:
Reset (nrst=0 at a clk_in edge):
- State IDLE; div_scale=0, div_nrst=0, busy=0, cur_idx=0, done=0.
- Internal edge register and dwell counter cleared.
- Table contents are not reset: undefined until written.

Table writes:
- cfg_we in IDLE writes {cfg_scale, cfg_dwell} to entry cfg_addr at the clock edge.
- cfg_we while busy=1 is ignored; the table is unchanged.

Edge detection:
- div_clk_q registers div_clk every cycle.
- rise = div_clk & ~div_clk_q.

States:
- IDLE:
  - div_nrst=0; div_scale holds its last value.
  - start=1 and stop=0: capture num_last, set cur_idx=0, go to LOAD.
- LOAD: exactly 2 cycles.
  - div_scale = table[cur_idx].scale, registered on entry to LOAD.
  - div_nrst=0, so the divider captures the scale.
  - Dwell counter cleared; then go to RUN.
- RUN:
  - div_nrst=1.
  - If div_scale != 0: counter increments on each rise.
  - If div_scale == 0: the divider passes clk_in through, so the counter increments every clk_in cycle.
  - When the counter reaches the effective dwell, go to NEXT. A dwell of 0 is treated as 1.
- NEXT: 1 cycle, div_nrst=0.
  - If cur_idx != captured num_last: cur_idx+1, go to LOAD.
  - Else if loop_en=1: cur_idx=0, go to LOAD.
  - Else: done=1 for this cycle, go to IDLE.

Latency:
- start sampled at edge k → div_nrst low during cycles k+1 and k+2 → div_nrst high from k+3.

stop:
- stop=1 in any non-IDLE state: next state is IDLE with div_nrst=0.
- No done pulse.
- stop and start together in IDLE: stop wins.

start:
- start while busy is ignored.

Counters:
- The dwell counter is DWELL_W bits and saturates; it never wraps.
- cur_idx wraps only via NEXT.

Mid-operation reset:
- nrst=0 in any state forces the reset values on the next edge.

Decomposition:
- Package clkdiv_seq_pkg:
  - state enum {IDLE, LOAD, RUN, NEXT}
  - LOAD_CYCLES = 2
  - entry struct {scale, dwell}, parameterised widths through localparams
- Sub-module clkdiv_seq_table: DEPTH-entry register file, one write port, one asynchronous read port indexed by cur_idx.

Test Plan:
- Reset then idle → div_nrst=0, div_scale=0, busy=0, done=0; cfg_we with busy=0 writes the entry.
- Entry0 {scale=2, dwell=3}, num_last=0, loop_en=0, start pulse → div_nrst low 2 cycles; high for 3 div_clk rises; NEXT; done pulses once; IDLE.
- Entries {1,2}, {3,1}, {0,5}, num_last=2, loop_en=0 → div_scale 1→3→0. The scale-0 entry dwells exactly 5 clk_in cycles; cur_idx 0,1,2; single done.
- Same table, loop_en=1 → cur_idx sequence 0,1,2,0,1; no done. stop in RUN → IDLE next cycle, div_nrst=0, no done.
- dwell=0 entry → behaves as dwell=1. cfg_we during RUN → table unchanged, confirmed by the next pass. start and stop asserted together → remains IDLE.
- nrst=0 asserted mid-RUN for 1 cycle → all outputs at reset values; a new start restarts from entry 0.
